vector_op_sequencer: RTL and testbench
======================================

VECTOR_OP_SEQUENCER -- requirements
Module: vector_op_sequencer

Interface
REQ-001 Parameter OP_LOAD, default 3'o1, is the opcode field emitted for load instructions.
REQ-002 Parameter OP_STORE, default 3'o2, is the opcode field emitted for store instructions.
REQ-003 Parameter ALU_REG, default 3'o0, is the ALU register field used in every emitted instruction.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high, with ports clk and reset.
REQ-005 The ports SHALL be as follows:
  clk          in   1  rising-edge clock
  reset        in   1  synchronous active-high reset
  start        in   1  command request; sampled only in IDLE
  abort        in   1  cancel the running command
  cmd_op       in   3  ALU opcode for the EXEC step
  a_base       in   3  first source memory address
  b_base       in   3  second source memory address
  dst_base     in   3  destination memory address
  len          in   3  element count; 0 means 8
  inst_ready   in   1  execution engine accepts the instruction
  inst_out     out  9  instruction {opcode[8:6], mem_addr[5:3], alu_reg[2:0]}
  inst_valid   out  1  inst_out is valid
  busy         out  1  high in any state other than IDLE
  done         out  1  one-cycle completion pulse
  elem_idx     out  3  index of the current element
  stall_cnt    out  8  stall counter (see Configuration)

Function
REQ-006 The FSM SHALL have the states IDLE, LOAD, EXEC, STORE and DONE, all encoded in registers.
REQ-007 In IDLE, start=1 SHALL capture cmd_op, a_base, b_base, dst_base and len, clear elem_idx, and transition to LOAD.
REQ-008 Changes to the command inputs after capture SHALL have no effect; start SHALL be ignored in any state other than IDLE.
REQ-009 inst_valid SHALL equal 1 in the LOAD, EXEC and STORE states and 0 otherwise.
REQ-010 The instruction driven in each state SHALL be:
  LOAD: {OP_LOAD, a_base+elem_idx, ALU_REG}
  EXEC: {cmd_op, b_base+elem_idx, ALU_REG}
  STORE: {OP_STORE, dst_base+elem_idx, ALU_REG}
REQ-011 Address sums SHALL be 3-bit modulo 8, so they wrap 7 to 0.
REQ-012 The state SHALL advance only on a clock edge where inst_valid and inst_ready are both 1; otherwise the state and inst_out SHALL hold stable.
REQ-013 When a STORE handshake completes:
  if elem_idx equals the effective length minus 1, the FSM SHALL go to DONE;
  otherwise elem_idx SHALL increment and the FSM SHALL go to LOAD.
REQ-014 The DONE state SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-015 Latency: with inst_ready held at 1, start sampled at edge N SHALL give the first inst_valid in cycle N+1 and done in cycle N+1+3*L, where L is the effective length.
REQ-016 abort=1 in LOAD, EXEC, STORE or DONE SHALL force IDLE at the next edge with no done pulse.
REQ-017 If a handshake coincides with abort, that instruction SHALL count as transferred and abort still takes effect.
REQ-018 abort and start both high in IDLE: abort SHALL win and start SHALL be ignored.
REQ-019 inst_out, inst_valid, busy and done SHALL be decoded from registered state only, with no combinational path from any input.
REQ-020 inst_out SHALL be 9'o000 whenever inst_valid=0.

Reset
REQ-021 reset=1 SHALL force the following at the next edge, overriding every other input:
  state IDLE
  inst_valid=0, inst_out=9'o000, busy=0, done=0, elem_idx=0, stall_cnt=0
  all captured command fields cleared to 0
REQ-022 A reset asserted mid-command SHALL discard the command; no done pulse SHALL follow.

Configuration
REQ-023 The macro SEQ_STALL_CNT_EN controls the stall counter.
REQ-024 With SEQ_STALL_CNT_EN defined:
  stall_cnt SHALL increment on each cycle where inst_valid=1 and inst_ready=0, saturating at 8'hFF;
  it SHALL clear on reset and on each accepted start.
REQ-025 With SEQ_STALL_CNT_EN undefined, stall_cnt SHALL be tied to 8'h00 and no counter logic SHALL be present; all other behaviour SHALL be identical.

Verification
REQ-026 Basic sequence: inst_ready=1, len=2, a_base=6, b_base=3, dst_base=0, cmd_op=4, start pulse -> inst_out sequence 9'o160, 9'o430, 9'o200, 9'o170, 9'o440, 9'o210, then done=1 for one cycle, 7 cycles after start.
REQ-027 Wrap: len=2, a_base=7, b_base=7, dst_base=7 -> the second element emits 9'o100, {cmd_op,3'o0,3'o0} and 9'o200.
REQ-028 Backpressure: inst_ready=0 for 3 cycles during the first EXEC -> inst_out holds steady; with the macro defined, stall_cnt=3 at done.
REQ-029 Length 0: len=0, ready=1 -> 24 instructions, elem_idx runs 0 to 7, done 25 cycles after start.
REQ-030 Abort and start-while-busy:
  abort during STORE of element 0 of a len=3 command -> IDLE next cycle, busy=0, no done;
  start while busy -> ignored.
REQ-031 Reset mid-command: reset during EXEC -> all outputs at their reset values next cycle; a new start then produces a clean sequence.

Source files
------------

// File: rtl/vector_op_sequencer.sv
// vector_op_sequencer
// Walks a vector command element by element, emitting a LOAD / EXEC / STORE
// instruction triple per element to an execution engine with a valid/ready
// handshake.
// Optional feature: define SEQ_STALL_CNT_EN to build the stall counter.
// Without it, stall_cnt is tied to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs quiet
// S_LOAD  | presenting load of a_base+elem_idx
// S_EXEC  | presenting ALU op cmd_op on b_base+elem_idx
// S_STORE | presenting store to dst_base+elem_idx
// S_DONE  | one-cycle completion pulse, then back to S_IDLE
module vector_op_sequencer #(
  parameter logic [2:0] OP_LOAD  = 3'o1,
  parameter logic [2:0] OP_STORE = 3'o2,
  parameter logic [2:0] ALU_REG  = 3'o0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] cmd_op,
  input  logic [2:0] a_base,
  input  logic [2:0] b_base,
  input  logic [2:0] dst_base,
  input  logic [2:0] len,
  input  logic       inst_ready,
  output logic [8:0] inst_out,
  output logic       inst_valid,
  output logic       busy,
  output logic       done,
  output logic [2:0] elem_idx,
  output logic [7:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EXEC  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state;
  logic [2:0] op_r;
  logic [2:0] a_r;
  logic [2:0] b_r;
  logic [2:0] dst_r;
  // Index of the final element; len=0 wraps to 7, giving 8 elements.
  logic [2:0] last_r;

  // Sequencer FSM; every output is loaded alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_r       <= 3'd0;
      a_r        <= 3'd0;
      b_r        <= 3'd0;
      dst_r      <= 3'd0;
      last_r     <= 3'd0;
      elem_idx   <= 3'd0;
      inst_out   <= 9'o000;
      inst_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      inst_out   <= 9'o000;
      inst_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r       <= cmd_op;
            a_r        <= a_base;
            b_r        <= b_base;
            dst_r      <= dst_base;
            last_r     <= len - 3'd1;
            elem_idx   <= 3'd0;
            state      <= S_LOAD;
            inst_valid <= 1'b1;
            busy       <= 1'b1;
            inst_out   <= {OP_LOAD, a_base, ALU_REG};
          end
        end
        S_LOAD: begin
          if (inst_ready) begin
            state    <= S_EXEC;
            inst_out <= {op_r, b_r + elem_idx, ALU_REG};
          end
        end
        S_EXEC: begin
          if (inst_ready) begin
            state    <= S_STORE;
            inst_out <= {OP_STORE, dst_r + elem_idx, ALU_REG};
          end
        end
        S_STORE: begin
          if (inst_ready) begin
            if (elem_idx == last_r) begin
              state      <= S_DONE;
              inst_valid <= 1'b0;
              inst_out   <= 9'o000;
              done       <= 1'b1;
            end else begin
              state    <= S_LOAD;
              elem_idx <= elem_idx + 3'd1;
              inst_out <= {OP_LOAD, a_r + elem_idx + 3'd1, ALU_REG};
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          inst_out   <= 9'o000;
          inst_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_STALL_CNT_EN
  // Saturating count of cycles an instruction waited on the engine.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 8'h00;
    end else if (state == S_IDLE && start && !abort) begin
      stall_cnt <= 8'h00;
    end else if (inst_valid && !inst_ready && stall_cnt != 8'hFF) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`else
  assign stall_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Self-checking bench for vector_op_sequencer.
// Expected instruction streams come from a per-command list built directly
// from the addressing rules; ready, abort and reset are applied per cycle.
module tb_vector_op_sequencer;

  localparam logic [2:0] M_LOAD  = 3'o1;
  localparam logic [2:0] M_STORE = 3'o2;
  localparam logic [2:0] M_ALU   = 3'o0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [2:0] a_base = 3'd0;
  logic [2:0] b_base = 3'd0;
  logic [2:0] dst_base = 3'd0;
  logic [2:0] len = 3'd0;
  logic       inst_ready = 1'b1;
  logic [8:0] inst_out;
  logic       inst_valid;
  logic       busy;
  logic       done;
  logic [2:0] elem_idx;
  logic [7:0] stall_cnt;

  int total = 0;
  int bad = 0;

  vector_op_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cmd_op(cmd_op), .a_base(a_base), .b_base(b_base), .dst_base(dst_base),
    .len(len), .inst_ready(inst_ready), .inst_out(inst_out),
    .inst_valid(inst_valid), .busy(busy), .done(done),
    .elem_idx(elem_idx), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input bit after_reset);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_out"}, 32'(inst_out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    if (after_reset) begin
      check({tag, "_idx"}, 32'(elem_idx), 32'd0);
      check({tag, "_stall"}, 32'(stall_cnt), 32'd0);
    end
  endtask

  // mode: 0 ready always, 1 random ready plus start noise, 2 three-cycle stall in first EXEC
  // kill_kind: 0 none, 1 abort, 2 reset; applied in the cycle instruction kill_at is presented
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic [2:0] ln, input int mode,
                         input int kill_kind, input int kill_at);
    logic [8:0] exp_q[$];
    int n, sent, stalls, cyc, held, done_cyc, exp_stall;
    bit killed;
    n = (ln == 3'd0) ? 8 : int'(ln);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({M_LOAD, 3'((int'(a) + i) % 8), M_ALU});
      exp_q.push_back({op,     3'((int'(b) + i) % 8), M_ALU});
      exp_q.push_back({M_STORE, 3'((int'(d) + i) % 8), M_ALU});
    end
    n = 3 * n;
    start = 1'b1; cmd_op = op; a_base = a; b_base = b; dst_base = d; len = ln;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cmd_op = 3'($urandom_range(0, 7)); a_base = 3'($urandom_range(0, 7));
    b_base = 3'($urandom_range(0, 7)); dst_base = 3'($urandom_range(0, 7));
    len = 3'($urandom_range(0, 7));
    sent = 0; stalls = 0; cyc = 0; held = 0; done_cyc = -1; killed = 0;
    while (1) begin
      if (cyc > 600) begin
        check("timeout", 32'd1, 32'd0);
        break;
      end
      inst_ready = 1'b1;
      if (mode == 1) begin
        inst_ready = ($urandom_range(0, 3) != 0);
        start = 1'($urandom_range(0, 1));
      end else if (mode == 2 && sent == 1 && held < 3) begin
        inst_ready = 1'b0;
        held++;
      end
      abort = (kill_kind == 1 && sent == kill_at);
      reset = (kill_kind == 2 && sent == kill_at);
      @(negedge clk);
      if (sent < n) begin
        check("valid", 32'(inst_valid), 32'd1);
        check("inst", 32'(inst_out), 32'(exp_q[sent]));
        check("idx", 32'(elem_idx), 32'(sent / 3));
        check("busy", 32'(busy), 32'd1);
        check("no_done", 32'(done), 32'd0);
        if (!inst_ready) stalls++;
      end else begin
        done_cyc = cyc;
        check("done", 32'(done), 32'd1);
        check("done_valid", 32'(inst_valid), 32'd0);
        check("done_out", 32'(inst_out), 32'd0);
`ifdef SEQ_STALL_CNT_EN
        exp_stall = (stalls > 255) ? 255 : stalls;
`else
        exp_stall = 0;
`endif
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      end
      @(posedge clk); #1;
      cyc++;
      if (abort || reset) begin
        killed = 1;
        break;
      end
      if (sent == n) break;
      if (inst_ready) sent++;
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0; inst_ready = 1'b1;
    if (mode == 0 && kill_kind == 0) check("latency", 32'(done_cyc), 32'(n));
    @(negedge clk);
    check_quiet(killed ? "after_kill" : "after_done", kill_kind == 2);
    @(posedge clk); #1;
    @(negedge clk);
    check("late_done", 32'(done), 32'd0);
    check("late_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("reset", 1'b1);
    @(posedge clk); #1;

    // basic two-element sequence
    run_cmd(3'd4, 3'd6, 3'd3, 3'd0, 3'd2, 0, 0, 0);
    // address wrap
    run_cmd(3'd5, 3'd7, 3'd7, 3'd7, 3'd2, 0, 0, 0);
    // backpressure during the first EXEC
    run_cmd(3'd4, 3'd6, 3'd3, 3'd0, 3'd2, 2, 0, 0);
    // len=0 means eight elements
    run_cmd(3'd3, 3'd1, 3'd2, 3'd5, 3'd0, 0, 0, 0);
    // abort during STORE of element 0
    run_cmd(3'd6, 3'd0, 3'd4, 3'd2, 3'd3, 0, 1, 2);
    // abort coinciding with a LOAD handshake
    run_cmd(3'd2, 3'd3, 3'd1, 3'd6, 3'd3, 0, 1, 3);

    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1; cmd_op = 3'd1; len = 3'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_quiet("idle_abort_start", 1'b0);
    @(posedge clk); #1;

    // reset during EXEC, then a clean command
    run_cmd(3'd7, 3'd2, 3'd5, 3'd1, 3'd3, 0, 2, 4);
    run_cmd(3'd4, 3'd6, 3'd3, 3'd0, 3'd2, 0, 0, 0);

    // randomized commands with random backpressure and ignored starts
    for (int k = 0; k < 24; k++) begin
      int kk, ka;
      kk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      ka = int'($urandom_range(0, 8));
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1, kk, ka);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
